// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8 data bits LSB first, odd parity, 2 stop bits,
// line idle high. One byte per accepted start_tx strobe.
//
// Ports:
//   clk       fabric clock
//   rst_n     synchronous active-low reset
//   start_tx  request strobe, only sampled while busy=0
//   din       byte to send, latched on the accepting edge
//   dout      registered serial line (idle 1)
//   busy      high while a frame is in flight
//   done      one-cycle pulse in the first idle cycle after a frame
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_tx,
  input  logic [7:0] din,
  output logic       dout,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_d;
  logic [7:0] shift_reg, shift_d;
  logic [7:0] timer, timer_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic       parity, parity_d;
  logic       dout_d, done_d;
  logic       bit_end;

  assign bit_end = (timer == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      timer     <= '0;
      bit_cnt   <= '0;
      parity    <= 1'b0;
      dout      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      timer     <= timer_d;
      bit_cnt   <= bit_cnt_d;
      parity    <= parity_d;
      dout      <= dout_d;
      busy      <= (state_d != IDLE);
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    shift_d   = shift_reg;
    timer_d   = timer + 8'd1;
    bit_cnt_d = bit_cnt;
    parity_d  = parity;
    done_d    = 1'b0;
    dout_d    = 1'b1;

    case (state)
      IDLE: begin
        timer_d = '0;
        if (start_tx) begin
          shift_d   = din;
          parity_d  = ~^din;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d   = '0;
          shift_d   = {1'b0, shift_reg[7:1]};
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_cnt_d = '0;   // reused to count the two stop bits
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd1) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so dout stays a plain flop
    // aligned with the state register.
    case (state_d)
      START:   dout_d = 1'b0;
      DATA:    dout_d = shift_d[0];
      PARITY:  dout_d = parity_d;
      default: dout_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CPB = 8;
  localparam int FRAME_CYC = 12 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_tx = 1'b1;
  logic [7:0] din = 8'hA5;
  logic       dout, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .start_tx(start_tx), .din(din),
    .dout(dout), .busy(busy), .done(done)
  );

  always #2.5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame from the line format: index 0 is the start bit, then
  // d0..d7, parity chosen so data+parity has an odd number of ones, 2 stops.
  function automatic logic [11:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, 1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  // Caller has start_tx=1/din=d set before the accepting edge. Checks every
  // cycle A+1..A+97. With noise, start_tx/din are scrambled while busy.
  // In cycle A+97 start_tx is set to chain (din=next_d) for back-to-back.
  task automatic run_frame(input string name, input logic [11:0] exp,
                           input bit noise, input bit chain, input logic [7:0] next_d);
    @(posedge clk);
    for (int t = 1; t <= FRAME_CYC + 1; t++) begin
      @(negedge clk);
      if (t <= FRAME_CYC) begin
        chk({name, "_dout"}, 32'(dout), 32'(exp[(t-1)/CPB]));
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_done"}, 32'(done), 32'd0);
        if (noise) begin
          start_tx = 1'($urandom_range(0, 1));
          din = 8'($urandom);
        end else begin
          start_tx = 1'b0;
        end
      end else begin
        chk({name, "_end_dout"}, 32'(dout), 32'd1);
        chk({name, "_end_busy"}, 32'(busy), 32'd0);
        chk({name, "_end_done"}, 32'(done), 32'd1);
        start_tx = chain;
        din = next_d;
      end
    end
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_idle_dout"}, 32'(dout), 32'd1);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_done"}, 32'(done), 32'd0);
  endtask

  // Loopback receiver: hunts for a low line, samples at mid-bit offset 4.
  logic        rx_en = 1'b0;
  logic [7:0]  rx_q[$];
  int          rx_corrupt = 0;
  logic [11:0] rx_f;
  int          rx_ones;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && dout === 1'b0) begin
        repeat (4) @(negedge clk);
        rx_f[0] = dout;
        for (int k = 1; k < 12; k++) begin
          repeat (CPB) @(negedge clk);
          rx_f[k] = dout;
        end
        rx_ones = 0;
        for (int k = 1; k <= 9; k++) rx_ones += int'(rx_f[k]);
        if (rx_f[0] !== 1'b0 || rx_f[10] !== 1'b1 || rx_f[11] !== 1'b1 || (rx_ones % 2) != 1)
          rx_corrupt++;
        else
          rx_q.push_back(rx_f[8:1]);
      end
    end
  end

  typedef struct {
    logic [7:0]  din;
    logic [11:0] frame;
    bit          noise;
    bit          chain;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] rb[256];
  logic [7:0] sent_q[$];
  bit         chained;
  bit         c;

  initial begin
    tbl[0] = '{8'h00, 12'hE00, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 12'hC02, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 12'hFFE, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 12'hCFE, 1'b0, 1'b0};
    tbl[4] = '{8'h3C, 12'hE78, 1'b1, 1'b1};
    tbl[5] = '{8'hC3, 12'hF86, 1'b0, 1'b0};

    // Reset held 3 cycles with start_tx high: line must stay idle.
    repeat (3) begin
      @(negedge clk);
      idle_chk("reset");
    end
    rst_n = 1'b1;   // first cycle out of reset is the acceptance cycle
    run_frame("a5", 12'hF4A, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    idle_chk("a5_after");

    chained = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!chained) begin
        @(negedge clk);
        idle_chk("tbl_pre");
        start_tx = 1'b1;
        din = tbl[i].din;
      end
      run_frame($sformatf("tbl%0d", i), tbl[i].frame, tbl[i].noise, tbl[i].chain,
                (tbl[i].chain && i < 5) ? tbl[i+1].din : 8'h00);
      chained = tbl[i].chain;
    end

    // Reset during data bit 3 of 0x55 (cycles A+33..A+40).
    @(negedge clk);
    start_tx = 1'b1;
    din = 8'h55;
    @(posedge clk);
    for (int t = 1; t <= 35; t++) begin
      @(negedge clk);
      start_tx = 1'b0;
      chk("r55_dout", 32'(dout), 32'(12'hEAA >> ((t-1)/CPB)) & 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    idle_chk("midrst");
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b1) begin
        chk("midrst_quiet", {29'd0, done, busy, dout}, 32'd1);
        break;
      end
    end
    start_tx = 1'b1;
    din = 8'h0F;
    run_frame("0f", 12'hE1E, 1'b0, 1'b0, 8'h00);

    // Random bytes, random gaps/noise/back-to-back, with loopback receiver.
    for (int i = 0; i < 256; i++) rb[i] = 8'($urandom);
    @(negedge clk);
    rx_en = 1'b1;
    chained = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (!chained) begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          idle_chk("rnd_gap");
        end
        start_tx = 1'b1;
        din = rb[i];
      end
      sent_q.push_back(rb[i]);
      c = (i < 255) && ($urandom_range(0, 3) == 0);
      run_frame("rnd", model_frame(rb[i]), 1'($urandom_range(0, 1)), c,
                c ? rb[(i + 1) % 256] : 8'h00);
      chained = c;
    end

    for (int w = 0; w < 200 && rx_q.size() < 256; w++) @(negedge clk);
    chk("rx_count", 32'(rx_q.size()), 32'd256);
    chk("rx_corrupt", 32'(rx_corrupt), 32'd0);
    for (int i = 0; i < 256 && i < rx_q.size(); i++)
      chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(sent_q[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
